modn_timer: RTL



---
 rtl/modn_timer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/modn_timer.sv
// Cascaded modulo-N down-counter with a run/pause/done controller for the
// countdown timer; each 4-bit digit has its own modulus taken from MODS.
module modn_timer #(
  parameter int                    DIGITS = 4,
  parameter logic [4*DIGITS-1:0]   MODS   = 16'hAA6A
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  loadn,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   out,
  output logic                  zero,
  output logic                  tc,
  output logic                  busy,
  output logic                  paused
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_nxt_state;
  logic [4*DIGITS-1:0]   r_cnt;
  logic [4*DIGITS-1:0]   w_nxt_cnt;
  logic [4*DIGITS-1:0]   w_dec;
  logic [4*DIGITS-1:0]   w_sat;
  logic                  w_nxt_tc;
  logic                  w_cnt_nz;
  logic                  r_zero;
  logic                  r_tc;
  logic                  r_busy;
  logic                  r_paused;

  // Digit i moves only while every lower digit is 0; a digit at 0 wraps.
  function automatic logic [4*DIGITS-1:0] f_dec(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] res;
    logic                borrow;
    logic [3:0]          d;
    logic [3:0]          m;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      m = MODS[4*i +: 4];
      if (borrow)
        res[4*i +: 4] = (d == 4'd0) ? (m - 4'd1) : (d - 4'd1);
      borrow = borrow & (d == 4'd0);
    end
    return res;
  endfunction

  function automatic logic [4*DIGITS-1:0] f_sat(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] res;
    logic [3:0]          d;
    logic [3:0]          m;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      m = MODS[4*i +: 4];
      res[4*i +: 4] = (d >= m) ? (m - 4'd1) : d;
    end
    return res;
  endfunction

  assign w_dec    = f_dec(r_cnt);
  assign w_sat    = f_sat(data);
  assign w_cnt_nz = (r_cnt != '0);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_tc    = 1'b0;
    if (!loadn && (r_state != RUN)) begin
      w_nxt_cnt   = w_sat;
      w_nxt_state = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start && w_cnt_nz)
            w_nxt_state = RUN;
        end
        RUN: begin
          if (pause) begin
            w_nxt_state = PAUSED;
          end else if (!w_cnt_nz) begin
            w_nxt_state = DONE;
          end else if (en) begin
            w_nxt_cnt = w_dec;
            if (w_dec == '0) begin
              w_nxt_tc    = 1'b1;
              w_nxt_state = DONE;
            end
          end
        end
        PAUSED: begin
          if (start)
            w_nxt_state = RUN;
        end
        DONE: begin
          w_nxt_state = DONE;
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_zero   <= 1'b1;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_zero   <= (w_nxt_cnt == '0);
      r_tc     <= w_nxt_tc;
      r_busy   <= (w_nxt_state == RUN);
      r_paused <= (w_nxt_state == PAUSED);
    end
  end

  assign out    = r_cnt;
  assign zero   = r_zero;
  assign tc     = r_tc;
  assign busy   = r_busy;
  assign paused = r_paused;

endmodule
